// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadows a DIGITS-nibble hex value and scans one digit per SCAN_DIV clocks.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    localparam int IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{SEG_ACTIVE_LOW}};

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h3F;
            4'h1: code = 7'h06;
            4'h2: code = 7'h5B;
            4'h3: code = 7'h4F;
            4'h4: code = 7'h66;
            4'h5: code = 7'h6D;
            4'h6: code = 7'h7D;
            4'h7: code = 7'h07;
            4'h8: code = 7'h7F;
            4'h9: code = 7'h6F;
            4'hA: code = 7'h77;
            4'hB: code = 7'h7C;
            4'hC: code = 7'h39;
            4'hD: code = 7'h5E;
            4'hE: code = 7'h79;
            default: code = 7'h71;
        endcase
        return code;
    endfunction

    logic [CNT_W-1:0]    cntP0;
    logic [IDX_W-1:0]    idxP0;
    logic [4*DIGITS-1:0] shadowP0;
    logic                wrapP0;

    logic                termCnt;
    logic                lastDigit;
    logic [3:0]          nibble;
    logic [DIGITS-1:0]   anHigh;
    logic [6:0]          segHigh;
    logic [6:0]          segNext;
    logic [DIGITS-1:0]   anNext;
    logic                blank;

    logic [6:0]          segP1;
    logic [DIGITS-1:0]   anP1;
    logic [IDX_W-1:0]    digitIdxP1;
    logic                frameP1;

    assign termCnt   = (cntP0 == CNT_W'(SCAN_DIV - 1));
    assign lastDigit = (idxP0 == IDX_W'(DIGITS - 1));

    // ---- stage p0: shadow capture, prescaler and digit index ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cntP0    <= '0;
            idxP0    <= '0;
            wrapP0   <= 1'b0;
            shadowP0 <= '0;
        end else begin
            if (load)
                shadowP0 <= data_in;
            if (termCnt) begin
                cntP0  <= '0;
                idxP0  <= lastDigit ? '0 : idxP0 + 1'b1;
                // Marks that idx just returned to digit 0; frame follows one stage later.
                wrapP0 <= lastDigit;
            end else begin
                cntP0  <= cntP0 + 1'b1;
                wrapP0 <= 1'b0;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic upperZero;

    // Digit k>0 is blanked while it and every more significant nibble are zero.
    always_comb begin
        upperZero = 1'b1;
        blank     = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upperZero = upperZero && (shadowP0[4*k +: 4] == 4'h0);
            if (int'(idxP0) == k)
                blank = upperZero;
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        nibble = 4'h0;
        anHigh = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (int'(idxP0) == k) begin
                nibble    = shadowP0[4*k +: 4];
                anHigh[k] = 1'b1;
            end
        end
        segHigh = blank ? 7'h00 : hexToSeg(nibble);
        if (blank)
            anHigh = '0;
        segNext = SEG_ACTIVE_LOW ? ~segHigh : segHigh;
        anNext  = SEG_ACTIVE_LOW ? ~anHigh  : anHigh;
    end

    // ---- stage p1: registered pin outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            segP1      <= SEG_OFF;
            anP1       <= AN_OFF;
            digitIdxP1 <= '0;
            frameP1    <= 1'b0;
        end else begin
            segP1      <= segNext;
            anP1       <= anNext;
            digitIdxP1 <= idxP0;
            frameP1    <= wrapP0;
        end
    end

    assign seg       = segP1;
    assign an        = anP1;
    assign digit_idx = digitIdxP1;
    assign frame     = frameP1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a cycle-count model checks every output cycle, directed literals pin key points.
// Two DUTs share the stimulus: one active-high, one active-low.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] dataIn = 16'h0000;

    logic [6:0] seg, segL;
    logic [3:0] an, anL;
    logic [1:0] dIdx, dIdxL;
    logic       frame, frameL;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(dataIn),
        .seg(seg), .an(an), .digit_idx(dIdx), .frame(frame)
    );

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dutL (
        .clk(clk), .rst(rst), .load(load), .data_in(dataIn),
        .seg(segL), .an(anL), .digit_idx(dIdxL), .frame(frameL)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---- behavioural model: position in the scan follows from edges counted since reset ----
    logic [6:0] segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          mTick;
    logic [15:0] mShadow;
    logic [6:0]  eSeg, eSegL;
    logic [3:0]  eAn, eAnL;
    int          eIdx;
    logic        eFrame;
    bit          mValid = 1'b0;

    always @(posedge clk) begin
        int   cur;
        bit   blk;
        logic [3:0] nib;
        if (rst) begin
            eSeg = 7'h00; eAn = 4'h0; eIdx = 0; eFrame = 1'b0;
            mShadow = 16'h0000;
            mTick = 0;
        end else begin
            cur = (mTick / SD) % D;
            nib = 4'((mShadow >> (4 * cur)) & 16'h000F);
`ifdef SEG7_LZ_BLANK_EN
            blk = (cur > 0) && ((mShadow >> (4 * cur)) == 16'h0000);
`else
            blk = 1'b0;
`endif
            eSeg   = blk ? 7'h00 : segTab[nib];
            eAn    = blk ? 4'h0 : 4'(1 << cur);
            eIdx   = cur;
            eFrame = (mTick > 0) && (mTick % (SD * D) == 0);
            if (load)
                mShadow = dataIn;
            mTick++;
        end
        eSegL = ~eSeg;
        eAnL  = ~eAn;
        mValid = 1'b1;
    end

    always @(negedge clk) begin
        if (mValid) begin
            check("seg", int'(seg), int'(eSeg));
            check("an", int'(an), int'(eAn));
            check("digit_idx", int'(dIdx), eIdx);
            check("frame", int'(frame), int'(eFrame));
            check("segL", int'(segL), int'(eSegL));
            check("anL", int'(anL), int'(eAnL));
            check("digit_idxL", int'(dIdxL), eIdx);
            check("frameL", int'(frameL), int'(eFrame));
        end
    end

    task automatic waitFrame();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (frame === 1'b1) break;
        end
        check("frame_wait", int'(k < 40), 1);
    endtask

    // ---- directed stimulus with literal expectations ----
    logic [6:0] scanSeg [4] = '{7'h71, 7'h77, 7'h5B, 7'h06};
`ifdef SEG7_LZ_BLANK_EN
    logic [6:0] lzSeg [4] = '{7'h3F, 7'h6D, 7'h00, 7'h00};
    logic [3:0] lzAn  [4] = '{4'h1, 4'h2, 4'h0, 4'h0};
`else
    logic [6:0] lzSeg [4] = '{7'h3F, 7'h6D, 7'h3F, 7'h3F};
    logic [3:0] lzAn  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
`endif

    initial begin
        int k;
        rst = 1'b1;
        step(3);
        check("rst_seg", int'(seg), 'h00);
        check("rst_an", int'(an), 'h0);
        check("rst_frame", int'(frame), 0);
        check("rstL_seg", int'(segL), 'h7F);
        check("rstL_an", int'(anL), 'hF);

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("first_seg", int'(seg), 'h3F);
            check("first_an", int'(an), 'h1);
            check("first_frame", int'(frame), 0);
            check("firstL_seg", int'(segL), 'h40);
            check("firstL_an", int'(anL), 'hE);
        end
        step(1);
        check("first_dwell_end", int'(dIdx), 1);

        // Full scan of 12AF
        load = 1'b1; dataIn = 16'h12AF;
        step(1);
        load = 1'b0;
        waitFrame();
        for (int i = 0; i < 16; i++) begin
            check("scan_seg", int'(seg), int'(scanSeg[i / 4]));
            check("scan_an", int'(an), 1 << (i / 4));
            step(1);
        end
        check("frame_period", int'(frame), 1);
        check("frame_seg", int'(seg), 'h71);
        check("frame_an", int'(an), 'h1);

        // Load on the terminal-count cycle of digit 0
        step(2);
        load = 1'b1; dataIn = 16'h0008;
        step(1);
        load = 1'b0;
        check("tc_old_seg", int'(seg), 'h71);
        step(1);
`ifdef SEG7_LZ_BLANK_EN
        check("tc_d1_seg", int'(seg), 'h00);
`else
        check("tc_d1_seg", int'(seg), 'h3F);
`endif
        check("tc_d1_idx", int'(dIdx), 1);
        waitFrame();
        check("tc_d0_seg", int'(seg), 'h7F);

        // Load mid-dwell on digit 0
        load = 1'b1; dataIn = 16'h0050;
        step(1);
        load = 1'b0;
        check("md_old_seg", int'(seg), 'h7F);
        step(1);
        check("md_new_seg", int'(seg), 'h3F);

        // Leading zeros of 0050
        waitFrame();
        for (int i = 0; i < 16; i++) begin
            check("lz_seg", int'(seg), int'(lzSeg[i / 4]));
            check("lz_an", int'(an), int'(lzAn[i / 4]));
            step(1);
        end
        load = 1'b1; dataIn = 16'h0000;
        step(1);
        load = 1'b0;
        waitFrame();
        check("zero_d0_seg", int'(seg), 'h3F);
        step(12);
        check("zero_d3_idx", int'(dIdx), 3);
`ifdef SEG7_LZ_BLANK_EN
        check("zero_d3_seg", int'(seg), 'h00);
        check("zero_d3_an", int'(an), 'h0);
`else
        check("zero_d3_seg", int'(seg), 'h3F);
        check("zero_d3_an", int'(an), 'h8);
`endif

        // Reset in the middle of a scan
        load = 1'b1; dataIn = 16'h8421;
        step(1);
        load = 1'b0;
        for (k = 0; k < 40; k++) begin
            step(1);
            if (an === 4'b0100) break;
        end
        check("an_0100_wait", int'(k < 40), 1);
        rst = 1'b1;
        step(1);
        check("midrst_an", int'(an), 'h0);
        check("midrst_seg", int'(seg), 'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("restart_seg", int'(seg), 'h3F);
            check("restart_an", int'(an), 'h1);
        end
        step(1);
        check("restart_dwell_end", int'(dIdx), 1);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
